conv_cmd_sequencer: RTL and testbench
=====================================

// Module: conv_cmd_sequencer
// PURPOSE
//   Issues the 8-bit Command byte to the command decoder that drives the R/L ROM/RAM resets and write enables.
//   Runs one full job per start request, in the order LOAD -> CONV -> WRITE -> PRINT -> END.
//   The job runs on the R channel, the L channel or both, as chosen by a 2-bit channel mask.
//   Each phase lasts a fixed number of cycles. Sits between the host/testbench start logic and the decoder.
// PARAMETERS
//   LOAD_CYC   4   cycles the LOAD_x command is held (must be >=1)
//   CONV_CYC   9   cycles CONV_x is held, one per kernel tap (>=1)
//   WRITE_CYC  9   cycles WRITE_x is held, one per RAM write (>=1)
//   PRINT_CYC  9   cycles PRINT_x is held, one per readout (>=1)
//   CNT_W      16  phase counter width; every *_CYC must be < 2**CNT_W
// PORTS
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high
//   start      in   1  job request; sampled only in IDLE
//   ch_mask    in   2  [0]=R, [1]=L; latched together with start
//   hold       in   1  stall: freezes the phase counter and holds the current command
//   abort      in   1  cancels the job and returns the block to IDLE
//   command    out  8  opcode to the decoder (registered)
//   busy       out  1  high from the first LOAD cycle to the last PRINT cycle
//   done       out  1  one-cycle pulse when a job completes normally
//   reject     out  1  one-cycle pulse when start arrives with ch_mask==2'b00
//   phase      out  3  current state encoding (debug/visibility)
// BEHAVIOUR
//   Opcodes: LOAD=8'h0M, CONV=8'h1M, WRITE=8'h2M, PRINT=8'h4M, END=8'h80.
//     M = {2'b00, latched mask}, so a job uses e.g. 8'h01 / 8'h12 / 8'h23.
//   Reset values: command=8'h80, busy=0, done=0, reject=0, phase=IDLE, counter=0, latched mask=0.
//   States: IDLE(0) LOAD(1) CONV(2) WRITE(3) PRINT(4) FIN(5). FIN is a single cycle.
//   IDLE: command=END.
//     start=1 and mask!=0: latch mask, go to LOAD. The first LOAD command appears in the cycle after start (latency 1).
//     start=1 and mask==0: pulse reject in the next cycle and stay in IDLE.
//   Phase timing: the counter clears on phase entry and increments each cycle while hold=0.
//     When counter==*_CYC-1 and hold=0, the next cycle enters the next phase, so each phase shows exactly *_CYC non-held cycles.
//   PRINT finishes -> FIN: command=END, busy=0, done=1 for one cycle. Next cycle -> IDLE.
//     A start in the FIN cycle is ignored.
//   hold=1 in any active phase: counter, state and command are all frozen. hold has no effect in IDLE or FIN.
//   abort=1 in any state: next cycle state=IDLE, command=END, busy=0, no done pulse, mask cleared.
//     abort has priority over hold and over start.
//   abort and the phase's last cycle together: abort wins and the next phase is not entered.
//   reset in the middle of a job: same result as abort, plus done and reject are cleared.
//   start while busy or in FIN: ignored, with no queuing and no reject.
//   command never takes a value outside the opcode set above. phase values 6 and 7 are unreachable and recover to IDLE.
// STRUCTURE
//   Shared package/header accel_cmd_pkg: opcode constants (OP_LOAD/CONV/WRITE/PRINT/END), state encodings, channel-mask bit positions.
//     The command decoder uses the same constants.
//   One sub-module: phase_counter (CNT_W bits; inputs clr, en, limit; output last). It is instantiated once and reloaded per phase.
//   FSM and command register live in this top level; command is a decode of the next state plus the latched mask, then registered.
// TESTING
//   1. reset, then start=1 with mask=2'b01 for one cycle.
//      Expect: 8'h01 x4, 8'h11 x9, 8'h21 x9, 8'h41 x9, then 8'h80 with done=1, then IDLE.
//   2. mask=2'b11. Expect opcodes 03/13/23/43 with the same lengths.
//      busy is high for exactly 31 cycles and done pulses exactly once.
//   3. mask=2'b00 with start=1. Expect reject=1 for one cycle, command stays 8'h80 and busy stays 0.
//   4. hold=1 for 5 cycles at CONV cycle 3. Expect 8'h12 held 14 cycles in total; WRITE then starts on schedule.
//   5. abort at WRITE cycle 2. Expect command=8'h80 and busy=0 the next cycle, no done pulse.
//      A new start is accepted the cycle after that.
//   6. reset pulsed during PRINT, and start pulsed during busy.
//      Reset gives all outputs their reset values. Start during busy is ignored and the job length is unchanged.

Source files
------------

// File: rtl/accel_cmd_pkg.sv
// Shared opcodes, sequencer state encodings and channel-mask bit positions.
// Also used by the command decoder so both sides agree on the opcode map.
package accel_cmd_pkg;

   localparam logic [7:0] OP_LOAD  = 8'h00;
   localparam logic [7:0] OP_CONV  = 8'h10;
   localparam logic [7:0] OP_WRITE = 8'h20;
   localparam logic [7:0] OP_PRINT = 8'h40;
   localparam logic [7:0] OP_END   = 8'h80;

   localparam int CH_R = 0;
   localparam int CH_L = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CONV  = 3'd2,
      ST_WRITE = 3'd3,
      ST_PRINT = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   // Opcode shown while in state s; the low nibble carries the channel mask.
   function automatic logic [7:0] cmd_of(state_e s, logic [1:0] m);
      logic [7:0] mm;
      mm = {6'b0, m};
      unique case (s)
         ST_LOAD:  cmd_of = OP_LOAD  | mm;
         ST_CONV:  cmd_of = OP_CONV  | mm;
         ST_WRITE: cmd_of = OP_WRITE | mm;
         ST_PRINT: cmd_of = OP_PRINT | mm;
         default:  cmd_of = OP_END;
      endcase
   endfunction

endpackage

// File: rtl/conv_cmd_sequencer_phase_counter.sv
// Reloadable phase-length counter; last flags the final cycle of a phase.
// A clear always wins over an increment.
module phase_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign last = (cnt_q == limit);

endmodule

// File: rtl/conv_cmd_sequencer.sv
// Job sequencer: LOAD -> CONV -> WRITE -> PRINT -> FIN on the masked channels.
// Outputs are registered decodes of the next state.
module conv_cmd_sequencer
   import accel_cmd_pkg::*;
#(
   parameter int LOAD_CYC  = 4,
   parameter int CONV_CYC  = 9,
   parameter int WRITE_CYC = 9,
   parameter int PRINT_CYC = 9,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] ch_mask,
   input  logic       hold,
   input  logic       abort,
   output logic [7:0] command,
   output logic       busy,
   output logic       done,
   output logic       reject,
   output logic [2:0] phase
);

   state_e           state_q, state_d;
   logic [1:0]       mask_q, mask_d;
   logic [7:0]       command_q;
   logic             busy_q, done_q, reject_q;
   logic             done_d, reject_d;
   logic             cnt_clr, cnt_en, cnt_last;
   logic [CNT_W-1:0] limit;

   always_comb begin
      unique case (state_q)
         ST_LOAD:  limit = CNT_W'(LOAD_CYC - 1);
         ST_CONV:  limit = CNT_W'(CONV_CYC - 1);
         ST_WRITE: limit = CNT_W'(WRITE_CYC - 1);
         ST_PRINT: limit = CNT_W'(PRINT_CYC - 1);
         default:  limit = '0;
      endcase
   end

   phase_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (limit),
      .last  (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      done_d   = 1'b0;
      reject_d = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && ch_mask != 2'b00) begin
                  mask_d  = ch_mask;
                  state_d = ST_LOAD;
                  cnt_clr = 1'b1;
               end else if (start) begin
                  reject_d = 1'b1;
               end
            end
            ST_LOAD, ST_CONV, ST_WRITE, ST_PRINT: begin
               if (!hold && cnt_last) begin
                  cnt_clr = 1'b1;
                  unique case (state_q)
                     ST_LOAD:  state_d = ST_CONV;
                     ST_CONV:  state_d = ST_WRITE;
                     ST_WRITE: state_d = ST_PRINT;
                     default: begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                     end
                  endcase
               end else if (!hold) begin
                  cnt_en = 1'b1;
               end
            end
            ST_FIN: begin
               state_d = ST_IDLE;
               mask_d  = '0;
            end
            default: begin
               state_d = ST_IDLE;
               mask_d  = '0;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mask_q    <= '0;
         command_q <= OP_END;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         command_q <= cmd_of(state_d, mask_d);
         busy_q    <= (state_d inside {ST_LOAD, ST_CONV, ST_WRITE, ST_PRINT});
         done_q    <= done_d;
         reject_q  <= reject_d;
      end
   end

   assign command = command_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign reject  = reject_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// Randomized and directed bench for conv_cmd_sequencer.
// Reference model: a queue of the commands still to be shown for the job.
module tb_conv_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, hold, abort;
   logic [1:0] ch_mask;
   logic [7:0] command;
   logic       busy, done, reject;
   logic [2:0] phase;

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt, done_cnt, c12_cnt;

   typedef struct {
      logic [7:0] cmd;
      bit         fin;
   } item_t;

   item_t q[$];
   bit    m_rej;

   conv_cmd_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .ch_mask (ch_mask),
      .hold    (hold),
      .abort   (abort),
      .command (command),
      .busy    (busy),
      .done    (done),
      .reject  (reject),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_job(logic [1:0] m);
      logic [7:0] ops [4];
      int         lens [4];
      item_t      it;
      ops = '{8'h00, 8'h10, 8'h20, 8'h40};
      lens = '{4, 9, 9, 9};
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < lens[p]; k++) begin
            it.cmd = ops[p] | {6'b0, m};
            it.fin = 1'b0;
            q.push_back(it);
         end
      end
      it.cmd = 8'h80;
      it.fin = 1'b1;
      q.push_back(it);
   endtask

   task automatic model_step();
      item_t t;
      m_rej = 1'b0;
      if (reset || abort) begin
         q.delete();
      end else if (q.size() == 0) begin
         if (start && ch_mask != 2'b00) push_job(ch_mask);
         else if (start) m_rej = 1'b1;
      end else if (q[0].fin || !hold) begin
         t = q.pop_front();
      end
   endtask

   function automatic int exp_phase();
      if (q.size() == 0) return 0;
      if (q[0].fin) return 5;
      case (q[0].cmd[7:4])
         4'h0:    return 1;
         4'h1:    return 2;
         4'h2:    return 3;
         default: return 4;
      endcase
   endfunction

   task automatic cycle();
      bit e_empty;
      model_step();
      @(posedge clk);
      #1;
      e_empty = (q.size() == 0);
      chk("command", command, e_empty ? 8'h80 : q[0].cmd);
      chk("busy", busy, !e_empty && !q[0].fin);
      chk("done", done, !e_empty && q[0].fin);
      chk("reject", reject, m_rej);
      chk("phase", phase, exp_phase());
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (command == 8'h12) c12_cnt++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clr_tally();
      busy_cnt = 0;
      done_cnt = 0;
      c12_cnt  = 0;
   endtask

   task automatic go(logic [1:0] m);
      start   = 1'b1;
      ch_mask = m;
      cycle();
      start   = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; ch_mask = 2'b00;
      run(2);
      reset = 1'b0;
      run(2);

      clr_tally();
      go(2'b01);
      run(35);
      chk("t1_done_cnt", done_cnt, 1);

      clr_tally();
      go(2'b11);
      run(35);
      chk("t2_busy_cnt", busy_cnt, 31);
      chk("t2_done_cnt", done_cnt, 1);

      clr_tally();
      go(2'b00);
      run(3);
      chk("t3_busy_cnt", busy_cnt, 0);

      clr_tally();
      go(2'b10);
      run(5);
      hold = 1'b1;
      run(5);
      hold = 1'b0;
      run(35);
      chk("t4_conv_len", c12_cnt, 14);
      chk("t4_done_cnt", done_cnt, 1);

      clr_tally();
      go(2'b01);
      run(14);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("t5_abort_cmd", command, 8'h80);
      go(2'b11);
      chk("t5_restart_cmd", command, 8'h03);
      run(35);
      chk("t5_done_cnt", done_cnt, 1);

      clr_tally();
      go(2'b01);
      run(9);
      start = 1'b1; ch_mask = 2'b11;
      cycle();
      start = 1'b0;
      run(30);
      chk("t6_busy_cnt", busy_cnt, 31);
      go(2'b10);
      run(25);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("t6_reset_cmd", command, 8'h80);
      run(3);

      for (int i = 0; i < 4000; i++) begin
         reset   = ($urandom_range(0, 299) == 0);
         abort   = ($urandom_range(0, 79) == 0);
         hold    = ($urandom_range(0, 4) == 0);
         start   = ($urandom_range(0, 3) == 0);
         ch_mask = 2'($urandom_range(0, 3));
         cycle();
      end
      reset = 1'b0; abort = 1'b0; hold = 1'b0; start = 1'b0;
      run(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
